// File: rtl/dmem_access_ctrl_if.sv
// Request/response and data-memory port bundle for the load/store initiator.
interface dmem_access_ctrl_if;
  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Response channel
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  // Word-indexed data memory port
  logic [31:0] mem_address;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;
  logic        mem_readmode;
  logic        mem_writemode;

  // Requester side: issues requests, consumes responses, and plays the memory.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataOut,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_dataIn, mem_readmode, mem_writemode
  );

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_dataOut,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_dataIn, mem_readmode, mem_writemode
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for a word-indexed data memory: one byte/half/word request at a time,
// sub-word stores done as read-modify-write, big-endian lane extraction with optional sign
// extension, and fault detection (misalignment, bad size, out-of-range word index).
module dmem_access_ctrl #(
  parameter int unsigned MEM_WORDS = 512
) (
  input  logic             clk,
  input  logic             reset,
  dmem_access_ctrl_if.slave bus_io
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        req_fault;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q;
  logic        resp_fault_q;
  logic [31:0] mem_address_q;
  logic [31:0] data_in_q;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state_q == StIdle) && bus_io.req_valid;

  // Reject a request at accept time so a faulting access never strobes the memory.
  always_comb begin
    req_fault = 1'b0;
    unique case (bus_io.req_size)
      2'b01:   req_fault = bus_io.req_addr[0];
      2'b10:   req_fault = (bus_io.req_addr[1:0] != 2'b00);
      2'b11:   req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
    if ({2'b00, bus_io.req_addr[31:2]} >= MEM_WORDS) req_fault = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state: loads and sub-word stores read first; word stores write directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_fault)                                           state_d = StResp;
          else if (bus_io.req_write && bus_io.req_size == 2'b10)   state_d = StWr;
          else                                                     state_d = StRd;
        end
      end
      StRd:    state_d = StCap;
      StCap:   state_d = write_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and memory strobes decode straight from the state.
  always_comb begin
    bus_io.req_ready     = 1'b0;
    bus_io.mem_readmode  = 1'b0;
    bus_io.mem_writemode = 1'b0;
    bus_io.resp_valid    = 1'b0;
    unique case (state_q)
      StIdle:  bus_io.req_ready     = 1'b1;
      StRd:    bus_io.mem_readmode  = 1'b1;
      StWr:    bus_io.mem_writemode = 1'b1;
      StResp:  bus_io.resp_valid    = 1'b1;
      default: ;
    endcase
  end

  // Big-endian lane selection from the word read back during CAP.
  always_comb begin
    unique case (off_q)
      2'd0:    lane_b = bus_io.mem_dataOut[31:24];
      2'd1:    lane_b = bus_io.mem_dataOut[23:16];
      2'd2:    lane_b = bus_io.mem_dataOut[15:8];
      default: lane_b = bus_io.mem_dataOut[7:0];
    endcase
    lane_h = off_q[1] ? bus_io.mem_dataOut[15:0] : bus_io.mem_dataOut[31:16];
    unique case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_val = bus_io.mem_dataOut;
    endcase
  end

  // Store merge: replace only the addressed lane, keep every other bit of the read word.
  always_comb begin
    merged = bus_io.mem_dataOut;
    if (size_q == 2'b00) begin
      unique case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  // Request capture, memory port registers and response registers.
  // Response registers only change on entry to RESP so they hold between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      off_q         <= 2'b00;
      wdata_q       <= '0;
      rdata_q       <= '0;
      resp_fault_q  <= 1'b0;
      mem_address_q <= '0;
      data_in_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            write_q       <= bus_io.req_write;
            size_q        <= bus_io.req_size;
            signed_q      <= bus_io.req_signed;
            off_q         <= bus_io.req_addr[1:0];
            wdata_q       <= bus_io.req_wdata[15:0];
            mem_address_q <= {2'b00, bus_io.req_addr[31:2]};
            if (req_fault) begin
              rdata_q      <= '0;
              resp_fault_q <= 1'b1;
            end else if (bus_io.req_write && bus_io.req_size == 2'b10) begin
              data_in_q <= bus_io.req_wdata;
            end
          end
        end
        StCap: begin
          if (write_q) begin
            data_in_q <= merged;
          end else begin
            rdata_q      <= load_val;
            resp_fault_q <= 1'b0;
          end
        end
        StWr: begin
          rdata_q      <= '0;
          resp_fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus_io.resp_rdata  = rdata_q;
  assign bus_io.resp_fault  = resp_fault_q;
  assign bus_io.mem_address = mem_address_q;
  assign bus_io.mem_dataIn  = data_in_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural memory/reference model.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.MEM_WORDS(512)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Data memory: registered read on readmode, write on writemode.
  logic [31:0] mem [0:511];
  int          rd_cnt, wr_cnt, both_cnt;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      bus.mem_dataOut <= 32'h0;
      rd_cnt <= 0; wr_cnt <= 0; both_cnt <= 0;
      last_rd_addr <= 32'h0; last_wr_addr <= 32'h0; last_wr_data <= 32'h0;
    end else begin
      if (bus.mem_readmode) begin
        bus.mem_dataOut <= mem[bus.mem_address[8:0]];
        rd_cnt          <= rd_cnt + 1;
        last_rd_addr    <= bus.mem_address;
      end
      if (bus.mem_writemode) begin
        mem[bus.mem_address[8:0]] <= bus.mem_dataIn;
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= bus.mem_address;
        last_wr_data <= bus.mem_dataIn;
      end
      if (bus.mem_readmode && bus.mem_writemode) both_cnt <= both_cnt + 1;
    end
  end

  // Reference model: expected outcome of one request, updating its own memory image.
  logic [31:0] ref_mem [0:511];

  task automatic ref_op(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] er, output logic ef, output int el,
                        output int enr, output int enw);
    int unsigned idx = a >> 2;
    int          off = int'(a[1:0]);
    int          sh;
    logic [31:0] word, mask, v;
    er  = 32'h0;
    ef  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
          (idx >= 512);
    if (ef) begin
      el = 1; enr = 0; enw = 0;
    end else begin
      word = ref_mem[idx];
      if (sz == 2'd0) sh = 8 * (3 - off);
      else            sh = (off >= 2) ? 0 : 16;
      mask = (sz == 2'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
      if (!w) begin
        el = 3; enr = 1; enw = 0;
        if (sz == 2'd2) begin
          er = word;
        end else begin
          v = (word & mask) >> sh;
          if (sg && sz == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
          if (sg && sz == 2'd1 && v[15]) v = v | 32'hFFFF0000;
          er = v;
        end
      end else if (sz == 2'd2) begin
        el = 2; enr = 0; enw = 1;
        ref_mem[idx] = wd;
      end else begin
        el = 4; enr = 1; enw = 1;
        ref_mem[idx] = (word & ~mask) | ((wd << sh) & mask);
      end
    end
  endtask

  // Drive one request, wait (bounded) for its response, and report what was observed.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic flt, output int lat,
                        output int nrd, output int nwr, output logic rdy_after);
    int rd0, wr0;
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; rdata = 32'h0; flt = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.resp_valid) begin
        lat = k; rdata = bus.resp_rdata; flt = bus.resp_fault;
        break;
      end
      @(posedge clk); #1;
    end
    nrd = rd_cnt - rd0; nwr = wr_cnt - wr0;
    @(posedge clk); #1;
    rdy_after = bus.req_ready;
  endtask

  logic [31:0] g_rd, e_rd;
  logic        g_f, e_f, g_rdy;
  int          g_lat, e_lat, g_nrd, e_nrd, g_nwr, e_nwr;

  task automatic test_reset();
    reset = 1'b1; mem_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_readmode,
         bus.mem_writemode} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000", {bus.req_ready, bus.resp_valid,
               bus.resp_fault, bus.mem_readmode, bus.mem_writemode});
    end
    n_cmp++;
    if ({bus.resp_rdata, bus.mem_address, bus.mem_dataIn} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h want 0", bus.resp_rdata, bus.mem_address,
               bus.mem_dataIn);
    end
    @(negedge clk);
    reset = 1'b0; mem_clear = 1'b0;
  endtask

  task automatic test_word_store_load();
    ref_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, e_rd, e_f, e_lat, e_nrd, e_nwr);
    do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    n_cmp++;
    if ({g_nrd, g_nwr, g_lat} !== {32'd0, 32'd1, 32'd2}) begin
      n_fail++; $display("FAIL sw_timing: got rd%0d wr%0d lat%0d want rd0 wr1 lat2",
                         g_nrd, g_nwr, g_lat);
    end
    n_cmp++;
    if (last_wr_addr !== 32'd4) begin
      n_fail++; $display("FAIL sw_addr: got %h want 4", last_wr_addr);
    end
    ref_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_rd, e_f, e_lat, e_nrd, e_nwr);
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    n_cmp++;
    if ({g_rd, g_f} !== {32'h11223344, 1'b0}) begin
      n_fail++; $display("FAIL lw_data: got %h f%b want 11223344 f0", g_rd, g_f);
    end
    n_cmp++;
    if ({g_lat, g_nrd, g_nwr} !== {32'd3, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL lw_timing: got lat%0d rd%0d wr%0d want lat3 rd1 wr0",
                         g_lat, g_nrd, g_nwr);
    end
  endtask

  task automatic test_subword_store();
    ref_op(1'b1, 2'd0, 1'b0, 32'h11, 32'hAA, e_rd, e_f, e_lat, e_nrd, e_nwr);
    do_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'hAA, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    n_cmp++;
    if ({g_lat, g_nrd, g_nwr} !== {32'd4, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL sb_timing: got lat%0d rd%0d wr%0d want lat4 rd1 wr1",
                         g_lat, g_nrd, g_nwr);
    end
    n_cmp++;
    if ({last_rd_addr, last_wr_addr, last_wr_data} !== {32'd4, 32'd4, 32'h11AA3344}) begin
      n_fail++; $display("FAIL sb_merge: got ra%h wa%h d%h want 4 4 11AA3344",
                         last_rd_addr, last_wr_addr, last_wr_data);
    end
    n_cmp++;
    if ({g_rd, g_f} !== 33'h0) begin
      n_fail++; $display("FAIL sb_resp: got %h f%b want 0 f0", g_rd, g_f);
    end
  endtask

  task automatic test_load_extend();
    logic [1:0]  szs [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        sgs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ads [4] = '{32'h20, 32'h20, 32'h22, 32'h20};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF};
    ref_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, e_rd, e_f, e_lat, e_nrd, e_nwr);
    do_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    for (int i = 0; i < 4; i++) begin
      ref_op(1'b0, szs[i], sgs[i], ads[i], 32'h0, e_rd, e_f, e_lat, e_nrd, e_nwr);
      do_txn(1'b0, szs[i], sgs[i], ads[i], 32'h0, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
      n_cmp++;
      if ({g_rd, g_f, g_lat} !== {exp[i], 1'b0, 32'd3}) begin
        n_fail++; $display("FAIL load_ext%0d: got %h f%b lat%0d want %h f0 lat3",
                           i, g_rd, g_f, g_lat, exp[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic        fw [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  fs [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] fa [4] = '{32'h13, 32'h12, 32'h10, 32'h800};
    for (int i = 0; i < 4; i++) begin
      do_txn(fw[i], fs[i], 1'b1, fa[i], 32'hFFFFFFFF, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
      n_cmp++;
      if ({g_rd, g_f, g_lat, g_nrd, g_nwr} !== {32'h0, 1'b1, 32'd1, 32'd0, 32'd0}) begin
        n_fail++; $display("FAIL fault%0d: got %h f%b lat%0d rd%0d wr%0d want 0 f1 lat1 0 0",
                           i, g_rd, g_f, g_lat, g_nrd, g_nwr);
      end
    end
    // Fault response registers hold until the next response.
    n_cmp++;
    if ({bus.resp_fault, bus.resp_rdata} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL fault_hold: got f%b %h want f1 0", bus.resp_fault,
                         bus.resp_rdata);
    end
    ref_op(1'b1, 2'd2, 1'b0, 32'h7FC, 32'hCAFEF00D, e_rd, e_f, e_lat, e_nrd, e_nwr);
    do_txn(1'b1, 2'd2, 1'b0, 32'h7FC, 32'hCAFEF00D, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    do_txn(1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    n_cmp++;
    if ({g_rd, g_f, g_lat, last_rd_addr} !== {32'hCAFEF00D, 1'b0, 32'd3, 32'd511}) begin
      n_fail++; $display("FAIL top_word: got %h f%b lat%0d a%h want CAFEF00D f0 lat3 1FF",
                         g_rd, g_f, g_lat, last_rd_addr);
    end
  endtask

  task automatic test_reset_mid_op();
    int wr0, seen;
    ref_op(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEADBEEF, e_rd, e_f, e_lat, e_nrd, e_nwr);
    do_txn(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEADBEEF, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    @(negedge clk);
    wr0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h31; bus.req_wdata = 32'h55;
    @(posedge clk); #1;             // accepted, now RD
    bus.req_valid = 1'b0;
    @(posedge clk); #1;             // CAP
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_ready: got %b want 1", bus.req_ready);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.resp_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({seen, wr_cnt - wr0} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL abort_quiet: got resp%0d wr%0d want 0 0", seen, wr_cnt - wr0);
    end
    n_cmp++;
    if (mem[12] !== ref_mem[12]) begin
      n_fail++; $display("FAIL abort_mem: got %h want %h", mem[12], ref_mem[12]);
    end
    ref_op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, e_rd, e_f, e_lat, e_nrd, e_nwr);
    do_txn(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
    n_cmp++;
    if ({g_rd, g_f, g_lat} !== {e_rd, e_f, e_lat}) begin
      n_fail++; $display("FAIL after_abort: got %h f%b lat%0d want %h f%b lat%0d",
                         g_rd, g_f, g_lat, e_rd, e_f, e_lat);
    end
  endtask

  task automatic test_back_to_back();
    int wr0, busy_rdy;
    logic [31:0] got;
    ref_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_rd, e_f, e_lat, e_nrd, e_nwr);
    @(negedge clk);
    wr0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    // Present a store while busy: it must be ignored, not queued.
    bus.req_write = 1'b1; bus.req_wdata = 32'hFFFFFFFF;
    busy_rdy = 0;
    for (int k = 0; k < 2; k++) begin
      if (bus.req_ready) busy_rdy++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    got = bus.resp_rdata;
    n_cmp++;
    if ({bus.resp_valid, got, busy_rdy} !== {1'b1, e_rd, 32'd0}) begin
      n_fail++; $display("FAIL busy_load: got v%b %h rdy%0d want v1 %h rdy0",
                         bus.resp_valid, got, busy_rdy, e_rd);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata} !== {1'b1, 1'b0, e_rd}) begin
      n_fail++; $display("FAIL ready_rise: got r%b v%b %h want r1 v0 %h",
                         bus.req_ready, bus.resp_valid, bus.resp_rdata, e_rd);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({wr_cnt - wr0, mem[4]} !== {32'd0, ref_mem[4]}) begin
      n_fail++; $display("FAIL ignored_req: got wr%0d %h want 0 %h", wr_cnt - wr0, mem[4],
                         ref_mem[4]);
    end
  endtask

  task automatic test_random();
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(512, 4000) << 2);
      else                          a = ($urandom_range(0, 7) << 2);
      a[1:0] = (sz == 2'd1 && $urandom_range(0, 3) != 0) ? 2'($urandom_range(0, 1) << 1) :
               (sz == 2'd2 && $urandom_range(0, 3) != 0) ? 2'd0 : 2'($urandom_range(0, 3));
      ref_op(w, sz, sg, a, wd, e_rd, e_f, e_lat, e_nrd, e_nwr);
      do_txn(w, sz, sg, a, wd, g_rd, g_f, g_lat, g_nrd, g_nwr, g_rdy);
      n_cmp++;
      if ({g_rd, g_f} !== {e_rd, e_f}) begin
        n_fail++; $display("FAIL rnd%0d_resp: w%b sz%0d a%h got %h f%b want %h f%b",
                           n, w, sz, a, g_rd, g_f, e_rd, e_f);
      end
      n_cmp++;
      if ({g_lat, g_nrd, g_nwr, 31'd0, g_rdy} !== {e_lat, e_nrd, e_nwr, 32'd1}) begin
        n_fail++; $display("FAIL rnd%0d_timing: got lat%0d rd%0d wr%0d rdy%b want %0d %0d %0d 1",
                           n, g_lat, g_nrd, g_nwr, g_rdy, e_lat, e_nrd, e_nwr);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL rnd_mem%0d: got %h want %h", i, mem[i], ref_mem[i]);
      end
    end
    n_cmp++;
    if (both_cnt !== 0) begin
      n_fail++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    reset = 1'b1; mem_clear = 1'b1;
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_load_extend();
    test_faults();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
